// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// for R-type, lw, sw, beq, addi and j; counts retired instructions; sticky halt.
// Optional build macro MEM_HANDSHAKE_EN adds a mem_ready input that stretches the
// memory states (FETCH, MEMRD, MEMWR) until the memory acknowledges.
module mc_control_fsm #(
    parameter logic [5:0]  HALT_OPCODE = 6'b111111,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef MEM_HANDSHAKE_EN
    input  logic             mem_ready,
`endif
    input  logic [5:0]       opcode,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dest,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic             retire_c;
    logic [CNT_W-1:0] instr_count_q;
    logic             mem_ready_c;

    // Registered control word; decoded from the next state so it tracks state_q exactly.
    logic       fetch_q,     fetch_d;
    logic       jump_pcw_q,  jump_pcw_d;
    logic       pcw_cond_q,  pcw_cond_d;
    logic       i_or_d_q,    i_or_d_d;
    logic       mem_read_q,  mem_read_d;
    logic       mem_write_q, mem_write_d;
    logic       mem_to_reg_q, mem_to_reg_d;
    logic       reg_dest_q,  reg_dest_d;
    logic       reg_write_q, reg_write_d;
    logic       src_a_q,     src_a_d;
    logic [1:0] src_b_q,     src_b_d;
    logic [1:0] alu_op_q,    alu_op_d;
    logic [1:0] pc_src_q,    pc_src_d;
    logic       halted_q,    halted_d;

`ifdef MEM_HANDSHAKE_EN
    assign mem_ready_c = mem_ready;
`else
    assign mem_ready_c = 1'b1;
`endif

    // Next-state, illegal-opcode detection and retirement detection.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        retire_c  = 1'b0;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  if (mem_ready_c) state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_RTYPE)                       state_d = S_EXEC;
                else if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = S_MEMADR;
                else if (opcode == OP_ADDI)                   state_d = S_ADDIEX;
                else if (opcode == OP_BEQ)                    state_d = S_BRANCH;
                else if (opcode == OP_J)                      state_d = S_JUMP;
                else if (opcode == HALT_OPCODE)               state_d = S_HALT;
                else begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready_c) state_d = S_MEMWB;
            S_MEMWB: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready_c) begin
                    state_d  = S_FETCH;
                    retire_c = 1'b1;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            S_ADDIEX: state_d = S_ADDIWB;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore output decode of the upcoming state.
    always_comb begin
        fetch_d      = 1'b0;
        jump_pcw_d   = 1'b0;
        pcw_cond_d   = 1'b0;
        i_or_d_d     = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        reg_dest_d   = 1'b0;
        reg_write_d  = 1'b0;
        src_a_d      = 1'b0;
        src_b_d      = 2'b00;
        alu_op_d     = 2'b00;
        pc_src_d     = 2'b00;
        halted_d     = 1'b0;
        case (state_d)
            S_FETCH: begin
                fetch_d    = 1'b1;
                mem_read_d = 1'b1;
                src_b_d    = 2'b01;
            end
            S_DECODE: src_b_d = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                src_a_d = 1'b1;
                src_b_d = 2'b10;
            end
            S_MEMRD: begin
                mem_read_d = 1'b1;
                i_or_d_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            S_MEMWR: begin
                mem_write_d = 1'b1;
                i_or_d_d    = 1'b1;
            end
            S_EXEC: begin
                src_a_d  = 1'b1;
                alu_op_d = 2'b10;
            end
            S_ALUWB: begin
                reg_write_d = 1'b1;
                reg_dest_d  = 1'b1;
            end
            S_ADDIWB: reg_write_d = 1'b1;
            S_BRANCH: begin
                src_a_d    = 1'b1;
                alu_op_d   = 2'b01;
                pcw_cond_d = 1'b1;
                pc_src_d   = 2'b01;
            end
            S_JUMP: begin
                jump_pcw_d = 1'b1;
                pc_src_d   = 2'b10;
            end
            S_HALT:  halted_d = 1'b1;
            default: ;
        endcase
    end

    // State, control word, illegal pulse and retired-instruction counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_RST;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
            fetch_q       <= 1'b0;
            jump_pcw_q    <= 1'b0;
            pcw_cond_q    <= 1'b0;
            i_or_d_q      <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            reg_dest_q    <= 1'b0;
            reg_write_q   <= 1'b0;
            src_a_q       <= 1'b0;
            src_b_q       <= 2'b00;
            alu_op_q      <= 2'b00;
            pc_src_q      <= 2'b00;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            illegal_q     <= illegal_d;
            if (retire_c) instr_count_q <= instr_count_q + CNT_W'(1);
            fetch_q       <= fetch_d;
            jump_pcw_q    <= jump_pcw_d;
            pcw_cond_q    <= pcw_cond_d;
            i_or_d_q      <= i_or_d_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
            reg_dest_q    <= reg_dest_d;
            reg_write_q   <= reg_write_d;
            src_a_q       <= src_a_d;
            src_b_q       <= src_b_d;
            alu_op_q      <= alu_op_d;
            pc_src_q      <= pc_src_d;
            halted_q      <= halted_d;
        end
    end

    // IR and PC loads in FETCH wait for the memory acknowledge.
    assign ir_write      = fetch_q & mem_ready_c;
    assign pc_write      = jump_pcw_q | (fetch_q & mem_ready_c);
    assign pc_write_cond = pcw_cond_q;
    assign i_or_d        = i_or_d_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_to_reg    = mem_to_reg_q;
    assign reg_dest      = reg_dest_q;
    assign reg_write     = reg_write_q;
    assign alu_src_a     = src_a_q;
    assign alu_src_b     = src_b_q;
    assign alu_op        = alu_op_q;
    assign pc_source     = pc_src_q;
    assign halted        = halted_q;
    assign illegal       = illegal_q;
    assign instr_count   = instr_count_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: an instruction-level model expands each
// opcode into its list of steps and checks the control word cycle by cycle.
module tb_mc_control_fsm;

    localparam int unsigned CNT_W = 32;

    // Instruction steps, named after the datapath activity of each cycle.
    localparam int ST_F = 0, ST_D = 1, ST_MA = 2, ST_MR = 3, ST_MWB = 4, ST_MW = 5,
                   ST_EX = 6, ST_AWB = 7, ST_AIX = 8, ST_AIWB = 9, ST_BR = 10,
                   ST_J = 11, ST_H = 12, ST_RST = 13;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [5:0]       opcode;
`ifdef MEM_HANDSHAKE_EN
    logic             mem_ready;
`endif
    logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic             mem_to_reg, reg_dest, reg_write, alu_src_a, halted, illegal;
    logic [1:0]       alu_src_b, alu_op, pc_source;
    logic [CNT_W-1:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned exp_count = 0;
    bit exp_ill_pending = 1'b0;

    mc_control_fsm #(.HALT_OPCODE(6'b111111), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
`ifdef MEM_HANDSHAKE_EN
        .mem_ready(mem_ready),
`endif
        .opcode(opcode),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dest(reg_dest), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .halted(halted), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [16:0] ctl_now;
    assign ctl_now = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dest, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, halted};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control word for one step; 'ready' is the memory acknowledge.
    function automatic logic [16:0] exp_ctl(input int st, input bit ready);
        logic pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, sa, h;
        logic [1:0] sb, aop, ps;
        {pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, sa, h} = '0;
        sb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (st)
            ST_F:    begin mr = 1; irw = ready; pcw = ready; sb = 2'b01; end
            ST_D:    sb = 2'b11;
            ST_MA:   begin sa = 1; sb = 2'b10; end
            ST_MR:   begin mr = 1; iod = 1; end
            ST_MWB:  begin rw = 1; m2r = 1; end
            ST_MW:   begin mw = 1; iod = 1; end
            ST_EX:   begin sa = 1; aop = 2'b10; end
            ST_AWB:  begin rw = 1; rd = 1; end
            ST_AIX:  begin sa = 1; sb = 2'b10; end
            ST_AIWB: rw = 1;
            ST_BR:   begin sa = 1; aop = 2'b01; pcwc = 1; ps = 2'b01; end
            ST_J:    begin pcw = 1; ps = 2'b10; end
            ST_H:    h = 1;
            default: ;
        endcase
        return {pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, h};
    endfunction

    // Steps an opcode walks through, starting from its FETCH.
    function automatic void build_steps(input logic [5:0] op, output int s[$], output bit retires);
        s = {ST_F, ST_D};
        retires = 1'b1;
        case (op)
            6'b000000: s = {s, ST_EX, ST_AWB};
            6'b100011: s = {s, ST_MA, ST_MR, ST_MWB};
            6'b101011: s = {s, ST_MA, ST_MW};
            6'b001000: s = {s, ST_AIX, ST_AIWB};
            6'b000100: s = {s, ST_BR};
            6'b000010: s = {s, ST_J};
            default:   retires = 1'b0;
        endcase
    endfunction

    function automatic bit is_mem_step(input int st);
        return (st == ST_F) || (st == ST_MR) || (st == ST_MW);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input string tag, input int st, input bit ready, input bit ill);
        #1;
        check({tag, ".ctl"}, 32'(ctl_now), 32'(exp_ctl(st, ready)));
        check({tag, ".illegal"}, 32'(illegal), 32'(ill));
        check({tag, ".count"}, instr_count, exp_count);
    endtask

    // Runs one instruction from its FETCH cycle up to (not including) the next FETCH.
    task automatic run_instr(input logic [5:0] op, input int max_wait);
        int  s[$];
        bit  ret;
        bit  first;
        int  w;
        build_steps(op, s, ret);
        opcode = op;
        first  = 1'b1;
        foreach (s[i]) begin
            if (i > 0) tick();
            w = 0;
`ifdef MEM_HANDSHAKE_EN
            if (is_mem_step(s[i])) w = $urandom_range(0, max_wait);
            for (int k = 0; k < w; k++) begin
                mem_ready = 1'b0;
                sample("wait", s[i], 1'b0, first && exp_ill_pending);
                first = 1'b0;
                tick();
            end
            mem_ready = 1'b1;
`endif
            sample("step", s[i], 1'b1, first && exp_ill_pending);
            first = 1'b0;
        end
        tick();
        if (ret) exp_count++;
        exp_ill_pending = !ret;
    endtask

    function automatic logic [5:0] rand_opcode();
        logic [5:0] legal [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010};
        logic [5:0] op;
        if ($urandom_range(0, 7) != 0) return legal[$urandom_range(0, 5)];
        do begin
            op = 6'($urandom);
        end while ((op inside {legal}) || (op == 6'b111111));
        return op;
    endfunction

    initial begin
        logic [5:0] seq [5] = '{6'b000000, 6'b101011, 6'b001000, 6'b000100, 6'b000010};
        reset_n = 1'b0;
        opcode  = 6'b100011;
`ifdef MEM_HANDSHAKE_EN
        mem_ready = 1'b1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        sample("reset", ST_RST, 1'b1, 1'b0);
        reset_n = 1'b1;
        tick();

        // lw after reset, then the directed opcode mix, then an illegal opcode.
        run_instr(6'b100011, 3);
        check("count_after_lw", instr_count, 32'd1);
        foreach (seq[i]) run_instr(seq[i], 3);
        check("count_after_mix", instr_count, 32'd6);
        run_instr(6'b010101, 3);
        run_instr(6'b000000, 3);

        for (int n = 0; n < 250; n++) run_instr(rand_opcode(), 3);

        // Asynchronous reset in the middle of MEMWR.
        opcode = 6'b101011;
        sample("sw_f", ST_F, 1'b1, exp_ill_pending);
        tick(); sample("sw_d", ST_D, 1'b1, 1'b0);
        tick(); sample("sw_ma", ST_MA, 1'b1, 1'b0);
        tick(); sample("sw_mw", ST_MW, 1'b1, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort.mem_write", 32'(mem_write), 32'd0);
        check("abort.count", instr_count, 32'd0);
        exp_count = 0;
        exp_ill_pending = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        sample("rst_state", ST_RST, 1'b1, 1'b0);
        tick();

        // HALT is absorbing; a reset pulse restarts from RST then FETCH.
        run_instr(6'b100011, 3);
        opcode = 6'b111111;
        sample("halt_f", ST_F, 1'b1, 1'b0);
        tick(); sample("halt_d", ST_D, 1'b1, 1'b0);
        for (int c = 0; c < 20; c++) begin
            tick();
            sample("halt", ST_H, 1'b1, 1'b0);
        end
        reset_n = 1'b0;
        exp_count = 0;
        sample("halt_rst", ST_RST, 1'b1, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        sample("halt_rel", ST_RST, 1'b1, 1'b0);
        tick();
        run_instr(6'b000100, 3);
        sample("final_f", ST_F, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
